// File: rtl/priority_arbiter_seq_if.sv
// Request/grant bundle for priority_arbiter_seq: request vector in, one granted index out.
// Handshake: out_idx transfers in any cycle where out_valid && out_ready; out_valid/out_idx hold while stalled.
interface priority_arbiter_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic [WIDTH-1:0] req;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] pending;
    logic             any_pending;

    modport master (
        output req, out_ready,
        input  out_valid, out_idx, pending, any_pending
    );

    modport slave (
        input  req, out_ready,
        output out_valid, out_idx, pending, any_pending
    );
endinterface

// File: rtl/priority_arbiter_seq.sv
// Sticky-request arbiter with a registered grant. Fixed priority (highest index wins) by default;
// define ROUND_ROBIN_EN to rotate the search below a pointer that follows the last transferred index.
module priority_arbiter_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    priority_arbiter_seq_if.slave bus
);
    logic [WIDTH-1:0] pending;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;

    logic             transfer;
    logic             load;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] sel;
    logic [IDX_W-1:0] win_idx;

    assign transfer = out_valid & bus.out_ready;
    assign load     = ~out_valid | transfer;

    always_comb begin
        clear = '0;
        if (transfer) begin
            clear[out_idx] = 1'b1;
        end
    end

    // Selection ignores this cycle's req, so a new request needs one cycle in pending first.
    assign sel = pending & ~clear;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    // Walk from the lowest-precedence candidate (ptr itself) up to ptr-1 so the last hit wins.
    always_comb begin
        win_idx = '0;
        for (int k = WIDTH; k >= 1; k--) begin
            if (sel[(int'(ptr) + WIDTH - k) % WIDTH]) begin
                win_idx = IDX_W'((int'(ptr) + WIDTH - k) % WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= out_idx;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            // OR-ing req after the clear lets a re-request survive its own transfer.
            pending <= sel | bus.req;
            if (load) begin
                out_valid <= |sel;
                out_idx   <= win_idx;
            end
        end
    end

    assign bus.pending     = pending;
    assign bus.any_pending = |pending;
    assign bus.out_valid   = out_valid;
    assign bus.out_idx     = out_idx;
endmodule

// File: doc/priority_arbiter_seq.md
PRIORITY_ARBITER_SEQ -- requirements
Module: priority_arbiter_seq

Interface
REQ-001 Parameter WIDTH, default 8: number of request inputs, legal range 2..256.
REQ-002 Parameter IDX_W, default 3: width of the encoded index; SHALL equal ceil(log2(WIDTH)).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req  input  WIDTH  request vector; bit i set means input i is requesting.
REQ-006 out_ready  input  1  consumer accepts the current out_idx.
REQ-007 out_valid  output  1  out_idx holds a valid granted index.
REQ-008 out_idx  output  IDX_W  encoded index of the granted request.
REQ-009 pending  output  WIDTH  registered sticky request vector.
REQ-010 any_pending  output  1  OR-reduction of pending (combinational from the register).

Function
REQ-011 Handshake: a transfer occurs in any cycle where out_valid=1 and out_ready=1.
REQ-012 Clear mask: onehot(out_idx) during a transfer, otherwise 0.
REQ-013 pending update: pending <= (pending & ~clear) | req.
REQ-014 Same-cycle clear and set on one bit: the set wins, so a re-request is never lost.
REQ-015 Selection set: sel = pending & ~clear, taken from the current register and excluding same-cycle req.
REQ-016 Output load: when out_valid=0 or a transfer occurs, out_valid <= |sel and out_idx <= encode(sel); otherwise out_valid and out_idx hold.
REQ-017 Stability: while out_valid=1 and out_ready=0, out_idx and out_valid do not change.
REQ-018 Fixed priority: the highest set index wins; bit WIDTH-1 has the highest priority.
REQ-019 When sel=0 at load time, out_valid <= 0 and out_idx <= 0.
REQ-020 Latency: a req pulse in cycle t appears in pending at t+1 and at the earliest on out_valid at t+2.
REQ-021 Throughput: one grant per cycle while out_ready=1 and sel is non-zero.
REQ-022 A granted bit stays set in pending until its transfer cycle.
REQ-023 The block has no X-propagation dependency: when out_valid=0, out_idx is 0.

Reset
REQ-024 When rst=1 at a clock edge: pending=0, out_valid=0, out_idx=0, and the round-robin pointer (if present) =0.
REQ-025 rst takes precedence over req and out_ready in the same cycle.
REQ-026 Reset mid-operation discards every pending and held grant; requests must be re-asserted after rst falls.

Configuration
REQ-027 Macro ROUND_ROBIN_EN selects the priority scheme.
REQ-028 With ROUND_ROBIN_EN defined: a pointer register ptr (IDX_W bits, reset 0) loads out_idx on each transfer.
REQ-029 With ROUND_ROBIN_EN defined: the search starts at ptr-1 and proceeds downward, wrapping from 0 to WIDTH-1; ptr itself is searched last. With ptr=0, the search order equals fixed priority.
REQ-030 Without ROUND_ROBIN_EN: fixed priority per REQ-018; there is no ptr register, and ports and latency are identical in both builds.

Verification (WIDTH=8)
REQ-031 Reset: apply rst=1 with req=8'hFF -> next cycle pending=0, out_valid=0, out_idx=0, any_pending=0.
REQ-032 Drain: one-cycle req=8'b1010_0100, out_ready=1 -> out_valid rises 2 cycles later; out_idx=7,5,2 on consecutive cycles, then out_valid=0 and pending=0.
REQ-033 Backpressure: req=8'h01 pulse with out_ready=0, later req=8'h80 pulse -> out_idx stays 0 and valid; on out_ready=1, idx 0 transfers, then 7 is granted.
REQ-034 Re-request: req[3] held high across idx 3's transfer -> pending[3] remains 1 and idx 3 is granted again later.
REQ-035 Mid-operation reset: pending=8'hFF with out_valid=1, then rst=1 for one cycle -> all outputs 0; no grant until a new req.
REQ-036 Mode: req=8'h83 held, out_ready=1 -> without the macro, out_idx sequence is 7,1,7,1; with ROUND_ROBIN_EN, the sequence is 7,1,0,7,1,0.
